// File: rtl/parking_gate_fsm_pkg.sv
// Shared types and defaults for the parking gate sequence detector.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTER1,
        ENTER2,
        ENTER3,
        EXIT1,
        EXIT2,
        EXIT3,
        ERR_WAIT
    } gate_state_e;

    localparam int DEBOUNCE_DEF = 16;
    localparam int TIMEOUT_DEF  = 1_000_000;

endpackage

// File: rtl/parking_gate_fsm_if.sv
// Gate sensor inputs and counter-facing pulse outputs of the parking gate FSM.
interface parking_gate_fsm_if;
    logic sensor_a;
    logic sensor_b;
    logic inc;
    logic dec;
    logic err;
    logic busy;

    modport master (output sensor_a, sensor_b, input inc, dec, err, busy);
    modport slave  (input sensor_a, sensor_b, output inc, dec, err, busy);
endinterface

// File: rtl/parking_gate_fsm_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer for one sensor line.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q, filt_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                // this edge is the DEBOUNCE_CYCLES-th differing sample
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign filt_o = filt_q;
endmodule

// File: rtl/parking_gate_fsm.sv
// Car passage sequence FSM: debounced sensors A/B -> inc/dec/err pulses and busy.
// Optional per-state stall timeout enabled by defining PARKING_GATE_TIMEOUT_EN.
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_DEF
) (
    input logic               clk,
    input logic               reset,
    parking_gate_fsm_if.slave gate
);
    logic        filt_a, filt_b;
    logic [1:0]  ab;
    gate_state_e state_q, state_d;
    logic        inc_q, dec_q, err_q, busy_q;
    logic        inc_d, dec_d, err_d;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .reset(reset), .raw_i(gate.sensor_a), .filt_o(filt_a)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .reset(reset), .raw_i(gate.sensor_b), .filt_o(filt_b)
    );

    assign ab = {filt_a, filt_b};

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_hit;
    assign tmo_hit = (state_q != IDLE) && (state_q != ERR_WAIT) &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: case (ab)
                2'b10:   state_d = ENTER1;
                2'b01:   state_d = EXIT1;
                2'b11:   begin state_d = ERR_WAIT; err_d = 1'b1; end
                default: ;
            endcase
            ENTER1: case (ab)
                2'b11:   state_d = ENTER2;
                2'b00:   state_d = IDLE;
                2'b01:   begin state_d = ERR_WAIT; err_d = 1'b1; end
                default: ;
            endcase
            ENTER2: case (ab)
                2'b01:   state_d = ENTER3;
                2'b10:   state_d = ENTER1;
                2'b00:   begin state_d = ERR_WAIT; err_d = 1'b1; end
                default: ;
            endcase
            ENTER3: case (ab)
                2'b00:   begin state_d = IDLE; inc_d = 1'b1; end
                2'b11:   state_d = ENTER2;
                2'b10:   begin state_d = ERR_WAIT; err_d = 1'b1; end
                default: ;
            endcase
            EXIT1: case (ab)
                2'b11:   state_d = EXIT2;
                2'b00:   state_d = IDLE;
                2'b10:   begin state_d = ERR_WAIT; err_d = 1'b1; end
                default: ;
            endcase
            EXIT2: case (ab)
                2'b10:   state_d = EXIT3;
                2'b01:   state_d = EXIT1;
                2'b00:   begin state_d = ERR_WAIT; err_d = 1'b1; end
                default: ;
            endcase
            EXIT3: case (ab)
                2'b00:   begin state_d = IDLE; dec_d = 1'b1; end
                2'b11:   state_d = EXIT2;
                2'b01:   begin state_d = ERR_WAIT; err_d = 1'b1; end
                default: ;
            endcase
            ERR_WAIT: if (ab == 2'b00) state_d = IDLE;
        endcase
`ifdef PARKING_GATE_TIMEOUT_EN
        // a stall overrides whatever the sensors are doing on this edge
        if (tmo_hit) begin
            state_d = ERR_WAIT;
            inc_d   = 1'b0;
            dec_d   = 1'b0;
            err_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PARKING_GATE_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
`ifdef PARKING_GATE_TIMEOUT_EN
            if (state_d != state_q || state_q == IDLE || state_q == ERR_WAIT)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + TW'(1);
`endif
        end
    end

    assign gate.inc  = inc_q;
    assign gate.dec  = dec_q;
    assign gate.err  = err_q;
    assign gate.busy = busy_q;
endmodule

// File: tb/tb_parking_gate_fsm.sv
// Directed plus randomized bench for parking_gate_fsm against a path-position reference model.
module tb_parking_gate_fsm;
    localparam int DB  = 4;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    parking_gate_fsm_if gif ();
    parking_gate_fsm #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .gate(gif)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_inc, cnt_dec, cnt_err, cnt_busy;

    // Reference model: sync pipe, sample windows, and position along the A/B path.
    bit m_s1[2], m_s2[2], m_f[2];
    bit win[2][$];
    int m_dir;   // 0 idle, 1 entering, 2 exiting
    int m_pos;   // index along 00,10,11,01 (entry view)
    int m_age;
    bit m_errw, m_inc, m_dec, m_err, m_busy;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int path_idx(int dir, bit a, bit b);
        bit x, y;
        x = (dir == 2) ? b : a;
        y = (dir == 2) ? a : b;
        if (!x && !y) return 0;
        if (x && !y)  return 1;
        if (x && y)   return 2;
        return 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_f[i] = 0; win[i].delete();
        end
        m_dir = 0; m_pos = 0; m_age = 0; m_errw = 0;
        m_inc = 0; m_dec = 0; m_err = 0; m_busy = 0;
    endtask

    task automatic model_edge(bit ra, bit rb, bit rs);
        bit fa, fb, pe;
        int np, d, pd, pp;
        if (!rs) begin model_reset(); return; end
        fa = m_f[0]; fb = m_f[1];
        pd = m_dir; pp = m_pos; pe = m_errw;
        m_inc = 0; m_dec = 0; m_err = 0;
        if (m_errw) begin
            if (!fa && !fb) m_errw = 0;
        end else if (m_dir == 0) begin
            if (fa && fb)  begin m_errw = 1; m_err = 1; end
            else if (fa)   begin m_dir = 1; m_pos = 1; end
            else if (fb)   begin m_dir = 2; m_pos = 1; end
        end
`ifdef PARKING_GATE_TIMEOUT_EN
        else if (m_age == TMO - 1) begin
            m_dir = 0; m_pos = 0; m_errw = 1; m_err = 1;
        end
`endif
        else begin
            np = path_idx(m_dir, fa, fb);
            d  = (np - m_pos + 4) % 4;
            if (d == 2) begin
                m_dir = 0; m_pos = 0; m_errw = 1; m_err = 1;
            end else if (d == 1) begin
                if (m_pos == 3) begin
                    m_inc = (m_dir == 1); m_dec = (m_dir == 2);
                    m_dir = 0; m_pos = 0;
                end else m_pos++;
            end else if (d == 3) begin
                m_pos--;
                if (m_pos == 0) m_dir = 0;
            end
        end
        if (m_dir != pd || m_pos != pp || m_errw != pe || m_dir == 0) m_age = 0;
        else m_age++;
        m_busy = m_errw || (m_dir != 0);
        // filtered bit flips once the last DB synchronised samples all disagree with it
        for (int i = 0; i < 2; i++) begin
            bit smp, all_diff;
            smp = m_s2[i];
            all_diff = 1;
            win[i].push_back(smp);
            if (win[i].size() > DB) void'(win[i].pop_front());
            if (win[i].size() < DB) all_diff = 0;
            foreach (win[i][k]) if (win[i][k] == m_f[i]) all_diff = 0;
            if (all_diff) m_f[i] = smp;
        end
        m_s2 = m_s1;
        m_s1[0] = ra; m_s1[1] = rb;
    endtask

    task automatic tick();
        bit ra, rb, rs;
        ra = gif.sensor_a; rb = gif.sensor_b; rs = reset;
        @(posedge clk);
        model_edge(ra, rb, rs);
        @(negedge clk);
        check("inc",  gif.inc,  m_inc);
        check("dec",  gif.dec,  m_dec);
        check("err",  gif.err,  m_err);
        check("busy", gif.busy, m_busy);
        check("onehot", ($countones({gif.inc, gif.dec, gif.err}) <= 1), 1);
        if (gif.inc === 1'b1)  cnt_inc++;
        if (gif.dec === 1'b1)  cnt_dec++;
        if (gif.err === 1'b1)  cnt_err++;
        if (gif.busy === 1'b1) cnt_busy++;
    endtask

    task automatic hold(bit a, bit b, int n);
        gif.sensor_a = a; gif.sensor_b = b;
        repeat (n) tick();
    endtask

    task automatic clr();
        cnt_inc = 0; cnt_dec = 0; cnt_err = 0; cnt_busy = 0;
    endtask

    initial begin
        int lat;
        gif.sensor_a = 1'b0; gif.sensor_b = 1'b0;
        model_reset();
        clr();

        // reset
        reset = 1'b0;
        repeat (3) tick();
        check("reset_busy", gif.busy, 0);
        check("reset_pulses", {gif.inc, gif.dec, gif.err}, 0);
        reset = 1'b1;
        hold(0, 0, 10);

        // full entry with latency from raw 00 to inc
        clr();
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
        gif.sensor_a = 0; gif.sensor_b = 0;
        lat = 0;
        do begin tick(); lat++; end while (gif.inc !== 1'b1 && lat < 20);
        check("entry_latency", lat, 7);
        hold(0, 0, 10);
        check("entry_inc", cnt_inc, 1);
        check("entry_dec_err", cnt_dec + cnt_err, 0);

        // full exit
        clr();
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 12);
        check("exit_dec", cnt_dec, 1);
        check("exit_inc_err", cnt_inc + cnt_err, 0);
        check("exit_busy_cycles", cnt_busy, 30);

        // glitch rejection
        clr();
        hold(1, 0, 3); hold(0, 0, 12);
        check("glitch_outputs", cnt_inc + cnt_dec + cnt_err + cnt_busy, 0);

        // back-out
        clr();
        hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 12);
        check("backout_pulses", cnt_inc + cnt_dec + cnt_err, 0);
        check("backout_idle", gif.busy, 0);

        // illegal simultaneous jump
        clr();
        hold(1, 1, 15);
        check("illegal_errwait_busy", gif.busy, 1);
        hold(0, 0, 12);
        check("illegal_err", cnt_err, 1);
        check("illegal_no_count", cnt_inc + cnt_dec, 0);
        check("illegal_idle", gif.busy, 0);

        // stall in ENTER1
        clr();
        gif.sensor_a = 1; gif.sensor_b = 0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (gif.err === 1'b1 && lat == 0) lat = i;
        end
        hold(0, 0, 12);
`ifdef PARKING_GATE_TIMEOUT_EN
        check("timeout_err_cycle", lat, 57);
        check("timeout_err_count", cnt_err, 1);
`else
        check("no_timeout_err", cnt_err, 0);
`endif
        check("timeout_no_count", cnt_inc + cnt_dec, 0);

        // reset while in ENTER3 aborts the car
        clr();
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
        gif.sensor_a = 0; gif.sensor_b = 0;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        hold(0, 0, 15);
        check("reset_abort_pulses", cnt_inc + cnt_dec + cnt_err, 0);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 150; i++) begin
            int mode;
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                bit dx;
                dx = 1'($urandom_range(0, 1));
                hold(!dx, dx, $urandom_range(5, 10));
                hold(1, 1, $urandom_range(5, 10));
                hold(dx, !dx, $urandom_range(5, 10));
                hold(0, 0, $urandom_range(5, 10));
            end else if (mode == 1) begin
                hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
            end else begin
                hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            end
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b0;
                repeat (2) tick();
                reset = 1'b1;
            end
        end
        hold(0, 0, 20);
        check("final_idle", gif.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/parking_gate_fsm.md
# parking_gate_fsm

Upstream stage of the parking-lot occupancy counter. Takes the two raw photo-sensor lines at the gate (outer sensor A, inner sensor B) and synchronises and debounces them. It then tracks the car-passage sequence with an FSM and emits single-cycle `inc` / `dec` pulses that drive the counter's `inc` / `dec` inputs directly. Aborted passages produce no pulse; malformed or stalled sequences are flagged.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required before a filtered sensor value changes; legal range ≥1.
- `TIMEOUT_CYCLES`, default 1_000_000: stall limit per non-idle state; used only with the timeout feature.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-low; sampled on posedge `clk`.
- `sensor_a` in 1: raw outer sensor, asynchronous, 1 = beam blocked.
- `sensor_b` in 1: raw inner sensor, asynchronous, 1 = beam blocked.
- `inc` out 1: one-cycle pulse, completed entry.
- `dec` out 1: one-cycle pulse, completed exit.
- `err` out 1: one-cycle pulse, illegal sequence or timeout.
- `busy` out 1: high when the FSM is not in IDLE.

## Operation
- Each sensor passes through a 2-flop synchroniser, then a debouncer.
- Debouncer behaviour:
  - Counts consecutive cycles in which the synchronised value differs from the filtered value.
  - The counter clears whenever the two values are equal.
  - The filtered value takes the synchronised value on the edge where the count reaches `DEBOUNCE_CYCLES`.
- FSM input is the filtered pair {A,B}. Transitions:
  - IDLE: 10→ENTER1; 01→EXIT1; 11→ERR_WAIT with `err`; 00 stays in IDLE.
  - ENTER1 (10): 11→ENTER2; 00→IDLE (back-out, no pulse); 01→ERR_WAIT with `err`.
  - ENTER2 (11): 01→ENTER3; 10→ENTER1; 00→ERR_WAIT with `err`.
  - ENTER3 (01): 00→IDLE with `inc`; 11→ENTER2; 10→ERR_WAIT with `err`.
  - EXIT1/EXIT2/EXIT3 mirror the ENTER states with A and B swapped. EXIT3 (10) going to 00 gives IDLE with `dec`.
  - ERR_WAIT: holds until the filtered pair is 00, then goes to IDLE. No pulses are issued in this state.
- Any input equal to the current state's own pattern keeps the state unchanged.
- Both filtered bits changing on the same edge is treated as the illegal jump listed above for that state.
- `inc` and `dec` are never high together. At most one of `inc`/`dec`/`err` is high in any cycle.
- This block does not saturate. Occupancy limits (0..99) are enforced by the counter.

## Timing
- Reset: `inc`, `dec`, `err`, `busy` = 0. State = IDLE. Synchroniser flops, filtered values, debounce and timeout counters = 0.
- Reset asserted mid-sequence aborts the sequence with no pulse. The first post-reset transition needs the full sync + debounce latency.
- Raw edge to filtered change: 2 + `DEBOUNCE_CYCLES` cycles, assuming the raw level stays stable.
- Outputs are registered. A pulse is high for exactly the one cycle after the edge on which the FSM leaves ENTER3/EXIT3 (or takes an error transition).
- `busy` is registered and reflects the FSM state from the previous edge.
- Back-to-back cars: a new sequence can start on the edge after returning to IDLE.

## Configuration
- `PARKING_GATE_TIMEOUT_EN` defined:
  - A per-state cycle counter clears on every state change and while in IDLE or ERR_WAIT.
  - If it reaches `TIMEOUT_CYCLES` in any ENTER/EXIT state, the FSM goes to ERR_WAIT and pulses `err`.
- Undefined: no counter is built. The FSM waits indefinitely in any state, and `err` arises only from illegal jumps.

## Structure
- Package `parking_pkg`: FSM state enum typedef (IDLE, ENTER1–3, EXIT1–3, ERR_WAIT) and default constants for debounce and timeout.
- Sub-module `sensor_debounce` (synchroniser plus debouncer, parameter `DEBOUNCE_CYCLES`), instantiated once per sensor.

## Test plan
(All scenarios use `DEBOUNCE_CYCLES`=4 and `TIMEOUT_CYCLES`=50.)
- Full entry: raw 00→10→11→01→00, each step held 10 cycles → exactly one `inc` pulse, 7 cycles after raw returns to 00 (sync + debounce + FSM + output register); no `dec`/`err`.
- Full exit: raw 00→01→11→10→00 → exactly one `dec` pulse; `busy` high from EXIT1 until IDLE.
- Glitch rejection: 3-cycle pulse on `sensor_a` while idle → filtered A never changes; no outputs; `busy` stays 0.
- Back-out: raw 00→10→11→10→00 → no pulse, FSM ends in IDLE.
- Illegal jump: from IDLE, raw 00→11 on both lines simultaneously → one `err` pulse, then ERR_WAIT until 00, then IDLE.
- Timeout (macro defined): hold raw 10 for 100 cycles → `err` pulse 50 cycles after entering ENTER1. Macro undefined: no `err`.
